// File: rtl/pipeline_register_file_pkg.sv
// Shared defaults, enable polarity and read-source selection for the register file.
package pipeline_register_file_pkg;

    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned ADDR_W_DEF    = 4;
    localparam int unsigned RESET_VAL_DEF = 0;
    localparam int unsigned SPECIAL_DEF   = 15;
    localparam int unsigned BYPASS_DEF    = 1;

    // Write and reserve strobes are active-low throughout the datapath.
    localparam logic EN_ACTIVE = 1'b0;

    // Where a read port takes its data from in the current cycle.
    typedef enum logic [1:0] {
        SRC_ARRAY = 2'd0,
        SRC_WR1   = 2'd1,
        SRC_WR2   = 2'd2
    } rd_src_e;

    function automatic logic enabled(input logic en_n);
        return en_n == EN_ACTIVE;
    endfunction

    // Write port 2 has priority over port 1 when both target the read address.
    function automatic rd_src_e pick_src(input logic bypass, input logic hit1, input logic hit2);
        if (bypass && hit2) begin
            return SRC_WR2;
        end
        if (bypass && hit1) begin
            return SRC_WR1;
        end
        return SRC_ARRAY;
    endfunction

endpackage

// File: rtl/pipeline_register_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on reserve, cleared on writeback.
module regfile_scoreboard
    import pipeline_register_file_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = BYPASS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr1_en,
    input  logic [ADDR_W-1:0] clr1_addr,
    input  logic              clr2_en,
    input  logic [ADDR_W-1:0] clr2_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd1_busy,
    output logic              rd2_busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam logic        BYP   = (BYPASS != 0);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clr_mask;

    // Decode set/clear masks; a reserve overrides a writeback to the same register.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) begin
            set_mask[set_addr] = 1'b1;
        end
        if (clr1_en) begin
            clr_mask[clr1_addr] = 1'b1;
        end
        if (clr2_en) begin
            clr_mask[clr2_addr] = 1'b1;
        end
        busy_next = set_mask | (busy & ~clr_mask);
    end

    // Busy bit storage, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Read ports: a register being written back (and not re-reserved) reads as free when bypassing.
    always_comb begin
        logic wr1_hit;
        logic wr2_hit;
        logic rsv1_hit;
        logic rsv2_hit;
        wr1_hit  = (clr1_en && (clr1_addr == rd1_addr)) || (clr2_en && (clr2_addr == rd1_addr));
        wr2_hit  = (clr1_en && (clr1_addr == rd2_addr)) || (clr2_en && (clr2_addr == rd2_addr));
        rsv1_hit = set_en && (set_addr == rd1_addr);
        rsv2_hit = set_en && (set_addr == rd2_addr);
        rd1_busy = busy[rd1_addr] && !(BYP && wr1_hit && !rsv1_hit);
        rd2_busy = busy[rd2_addr] && !(BYP && wr2_hit && !rsv2_hit);
    end

endmodule

// File: rtl/pipeline_register_file.sv
// Two-write/two-read register file with optional write-to-read bypass and a pending-write scoreboard.
module pipeline_register_file
    import pipeline_register_file_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned RESET_VAL = RESET_VAL_DEF,
    parameter int unsigned BYPASS    = BYPASS_DEF,
    parameter int unsigned SPECIAL   = SPECIAL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WriteAddress1,
    input  logic [DATA_W-1:0] WriteData1,
    input  logic              WE2,
    input  logic [ADDR_W-1:0] WriteAddress2,
    input  logic [DATA_W-1:0] WriteData2,
    input  logic              Rsv,
    input  logic [ADDR_W-1:0] RsvAddress,
    input  logic [ADDR_W-1:0] Op1,
    input  logic [ADDR_W-1:0] Op2,
    output logic [DATA_W-1:0] Op1Data,
    output logic [DATA_W-1:0] Op2Data,
    output logic              Op1Busy,
    output logic              Op2Busy,
    output logic [DATA_W-1:0] Reg15Data,
    output logic              WrConflict
);

    localparam int unsigned       DEPTH       = 2**ADDR_W;
    localparam logic              BYP         = (BYPASS != 0);
    localparam logic [DATA_W-1:0] RST_WORD    = DATA_W'(RESET_VAL);
    localparam logic [ADDR_W-1:0] SPECIAL_IDX = ADDR_W'(SPECIAL);

    logic [DATA_W-1:0] regs [DEPTH];

    logic we1;
    logic we2;
    logic rsv;
    logic dual_same;

    assign we1       = enabled(WE1);
    assign we2       = enabled(WE2);
    assign rsv       = enabled(Rsv);
    assign dual_same = we1 && we2 && (WriteAddress1 == WriteAddress2);

    // Data array; port 1 is suppressed when port 2 targets the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: RST_WORD};
        end else begin
            if (we1 && !dual_same) begin
                regs[WriteAddress1] <= WriteData1;
            end
            if (we2) begin
                regs[WriteAddress2] <= WriteData2;
            end
        end
    end

    // Flag a same-address dual write for exactly the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WrConflict <= 1'b0;
        end else begin
            WrConflict <= dual_same;
        end
    end

    // Read port A source select and mux.
    always_comb begin
        rd_src_e src1;
        src1 = pick_src(BYP, we1 && (WriteAddress1 == Op1), we2 && (WriteAddress2 == Op1));
        unique case (src1)
            SRC_WR2: Op1Data = WriteData2;
            SRC_WR1: Op1Data = WriteData1;
            default: Op1Data = regs[Op1];
        endcase
    end

    // Read port B source select and mux.
    always_comb begin
        rd_src_e src2;
        src2 = pick_src(BYP, we1 && (WriteAddress1 == Op2), we2 && (WriteAddress2 == Op2));
        unique case (src2)
            SRC_WR2: Op2Data = WriteData2;
            SRC_WR1: Op2Data = WriteData1;
            default: Op2Data = regs[Op2];
        endcase
    end

    assign Reg15Data = regs[SPECIAL_IDX];

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (rsv),
        .set_addr  (RsvAddress),
        .clr1_en   (we1),
        .clr1_addr (WriteAddress1),
        .clr2_en   (we2),
        .clr2_addr (WriteAddress2),
        .rd1_addr  (Op1),
        .rd2_addr  (Op2),
        .rd1_busy  (Op1Busy),
        .rd2_busy  (Op2Busy)
    );

endmodule

// File: tb/tb_pipeline_register_file.sv
// Directed bench for pipeline_register_file with a cycle-level reference model.
`timescale 1ns/1ps
module tb_pipeline_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WE1 = 1'b1;
    logic [3:0]  WriteAddress1 = '0;
    logic [15:0] WriteData1 = '0;
    logic        WE2 = 1'b1;
    logic [3:0]  WriteAddress2 = '0;
    logic [15:0] WriteData2 = '0;
    logic        Rsv = 1'b1;
    logic [3:0]  RsvAddress = '0;
    logic [3:0]  Op1 = '0;
    logic [3:0]  Op2 = '0;
    logic [15:0] Op1Data;
    logic [15:0] Op2Data;
    logic        Op1Busy;
    logic        Op2Busy;
    logic [15:0] Reg15Data;
    logic        WrConflict;

    int vectors    = 0;
    int miscompares = 0;
    logic checking = 1'b0;

    // Reference model state
    logic [15:0] m_regs [16];
    logic        m_busy [16];
    logic        m_conf;

    pipeline_register_file #(
        .DATA_W    (16),
        .ADDR_W    (4),
        .RESET_VAL (0),
        .BYPASS    (1),
        .SPECIAL   (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .WE1           (WE1),
        .WriteAddress1 (WriteAddress1),
        .WriteData1    (WriteData1),
        .WE2           (WE2),
        .WriteAddress2 (WriteAddress2),
        .WriteData2    (WriteData2),
        .Rsv           (Rsv),
        .RsvAddress    (RsvAddress),
        .Op1           (Op1),
        .Op2           (Op2),
        .Op1Data       (Op1Data),
        .Op2Data       (Op2Data),
        .Op1Busy       (Op1Busy),
        .Op2Busy       (Op2Busy),
        .Reg15Data     (Reg15Data),
        .WrConflict    (WrConflict)
    );

    always #5 clk = ~clk;

    task automatic check_d(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Model: later assignments take effect last, so port 2 beats port 1 and reserve beats clear.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] <= 16'h0000;
                m_busy[i] <= 1'b0;
            end
            m_conf <= 1'b0;
        end else begin
            m_conf <= !WE1 && !WE2 && (WriteAddress1 == WriteAddress2);
            if (!WE1) begin
                m_regs[WriteAddress1] <= WriteData1;
                m_busy[WriteAddress1] <= 1'b0;
            end
            if (!WE2) begin
                m_regs[WriteAddress2] <= WriteData2;
                m_busy[WriteAddress2] <= 1'b0;
            end
            if (!Rsv) begin
                m_busy[RsvAddress] <= 1'b1;
            end
        end
    end

    function automatic logic [15:0] exp_data(input logic [3:0] a);
        if (!WE2 && WriteAddress2 == a) return WriteData2;
        if (!WE1 && WriteAddress1 == a) return WriteData1;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [3:0] a);
        logic writing;
        logic reserving;
        writing   = (!WE1 && WriteAddress1 == a) || (!WE2 && WriteAddress2 == a);
        reserving = !Rsv && RsvAddress == a;
        return m_busy[a] && !(writing && !reserving);
    endfunction

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (checking) begin
            check_d("model_op1data", Op1Data, exp_data(Op1));
            check_d("model_op2data", Op2Data, exp_data(Op2));
            check_b("model_op1busy", Op1Busy, exp_busy(Op1));
            check_b("model_op2busy", Op2Busy, exp_busy(Op2));
            check_d("model_reg15", Reg15Data, m_regs[15]);
            check_b("model_wrconflict", WrConflict, m_conf);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WE1 = 1'b1;
        WE2 = 1'b1;
        Rsv = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and sweep
        #2 rst = 1'b0;
        checking = 1'b1;
        step();
        step();
        #2 rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            Op1 = 4'(i);
            Op2 = 4'(15 - i);
            #1;
            check_d("rst_op1data", Op1Data, 16'h0000);
            check_d("rst_op2data", Op2Data, 16'h0000);
            check_b("rst_op1busy", Op1Busy, 1'b0);
            check_b("rst_op2busy", Op2Busy, 1'b0);
            check_d("rst_reg15", Reg15Data, 16'h0000);
        end

        // Single writes on both ports
        step();
        WE1 = 1'b0; WriteAddress1 = 4'd0; WriteData1 = 16'hDEAD;
        WE2 = 1'b0; WriteAddress2 = 4'd1; WriteData2 = 16'hBEEF;
        step();
        idle();
        Op1 = 4'd0; Op2 = 4'd1;
        #1;
        check_d("single_op1", Op1Data, 16'hDEAD);
        check_d("single_op2", Op2Data, 16'hBEEF);
        check_b("single_noconflict", WrConflict, 1'b0);

        // Same-address dual write
        step();
        WE1 = 1'b0; WriteAddress1 = 4'd3; WriteData1 = 16'h1111;
        WE2 = 1'b0; WriteAddress2 = 4'd3; WriteData2 = 16'h2222;
        Op1 = 4'd3;
        #1;
        check_d("conflict_bypass", Op1Data, 16'h2222);
        step();
        idle();
        #1;
        check_b("conflict_flag", WrConflict, 1'b1);
        check_d("conflict_stored", Op1Data, 16'h2222);
        step();
        #1;
        check_b("conflict_oneshot", WrConflict, 1'b0);

        // Scoreboard set, clear and reserve-over-write
        step();
        Rsv = 1'b0; RsvAddress = 4'd5;
        step();
        Rsv = 1'b1;
        Op1 = 4'd5;
        #1;
        check_b("sb_set", Op1Busy, 1'b1);
        WE1 = 1'b0; WriteAddress1 = 4'd5; WriteData1 = 16'hA5A5;
        #1;
        check_b("sb_bypass_free", Op1Busy, 1'b0);
        check_d("sb_bypass_data", Op1Data, 16'hA5A5);
        step();
        idle();
        #1;
        check_b("sb_cleared", Op1Busy, 1'b0);
        check_d("sb_data", Op1Data, 16'hA5A5);
        Rsv = 1'b0; RsvAddress = 4'd6;
        step();
        WE1 = 1'b0; WriteAddress1 = 4'd6; WriteData1 = 16'h1234;
        Op2 = 4'd6;
        #1;
        check_b("sb_rsv_and_wr_now", Op2Busy, 1'b1);
        step();
        idle();
        #1;
        check_b("sb_rsv_wins", Op2Busy, 1'b1);
        check_d("sb_rsv_wr_data", Op2Data, 16'h1234);

        // Special register does not bypass
        step();
        WE2 = 1'b0; WriteAddress2 = 4'd15; WriteData2 = 16'hCAFE;
        Op1 = 4'd15;
        #1;
        check_d("reg15_before", Reg15Data, 16'h0000);
        check_d("reg15_op_bypass", Op1Data, 16'hCAFE);
        step();
        idle();
        #1;
        check_d("reg15_after", Reg15Data, 16'hCAFE);

        // Async reset in the middle of a cycle
        step();
        WE1 = 1'b0; WriteAddress1 = 4'd2; WriteData1 = 16'h7777;
        Rsv = 1'b0; RsvAddress = 4'd2;
        step();
        idle();
        Op1 = 4'd2; Op2 = 4'd2;
        #1;
        check_b("mid_pre_busy", Op1Busy, 1'b1);
        check_d("mid_pre_data", Op1Data, 16'h7777);
        WE1 = 1'b0; WriteData1 = 16'h8888;
        #1 rst = 1'b0;
        #1 WE1 = 1'b1;
        #2;
        check_d("mid_rst_data", Op1Data, 16'h0000);
        check_b("mid_rst_busy", Op1Busy, 1'b0);
        check_d("mid_rst_reg15", Reg15Data, 16'h0000);
        check_b("mid_rst_conflict", WrConflict, 1'b0);
        WE1 = 1'b0;
        step();
        WE1 = 1'b1;
        #1 rst = 1'b1;
        step();
        #1;
        check_d("mid_not_committed", Op1Data, 16'h0000);
        check_d("mid_other_cleared", Op2Data, 16'h0000);

        step();
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
